// File: rtl/pipe_stage_reg_if.sv
// Bus between a pipeline stage register and its driving logic: load/flush controls,
// the incoming slot, the registered slot, and the stall/flush event counters.
interface pipe_stage_reg_if #(
  parameter int PC_W  = 32,
  parameter int INS_W = 32,
  parameter int CNT_W = 16
);
  logic             wen;
  logic             flush;
  logic             d_valid;
  logic [PC_W-1:0]  d_pc4;
  logic [INS_W-1:0] d_ins;
  logic             cnt_clr;
  logic             q_valid;
  logic [PC_W-1:0]  q_pc4;
  logic [INS_W-1:0] q_ins;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output wen, flush, d_valid, d_pc4, d_ins, cnt_clr,
    input  q_valid, q_pc4, q_ins, stall_cnt, flush_cnt
  );

  modport slave (
    input  wen, flush, d_valid, d_pc4, d_ins, cnt_clr,
    output q_valid, q_pc4, q_ins, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// IF/ID-style stage register with stall, flush-to-NOP and saturating event counters.
// One cycle load latency; wen=0 holds the slot, flush overrides stall.
module pipe_stage_reg #(
  parameter int               PC_W    = 32,
  parameter int               INS_W   = 32,
  parameter logic [INS_W-1:0] NOP_INS = '0,
  parameter int               CNT_W   = 16
) (
  input  logic                clock,
  input  logic                reset,
  pipe_stage_reg_if.slave     bus
);

  logic             valid_q, valid_d;
  logic [PC_W-1:0]  pc4_q, pc4_d;
  logic [INS_W-1:0] ins_q, ins_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_ev, flush_ev;

  // Events are judged on the slot contents before the edge.
  assign stall_ev = !bus.flush && !bus.wen && valid_q;
  assign flush_ev = bus.flush && valid_q;

  always_comb begin
    valid_d = valid_q;
    pc4_d   = pc4_q;
    ins_d   = ins_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      ins_d   = NOP_INS;
    end else if (bus.wen) begin
      valid_d = bus.d_valid;
      pc4_d   = bus.d_pc4;
      ins_d   = bus.d_valid ? bus.d_ins : NOP_INS;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_ev && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_ev && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q     <= 1'b0;
      pc4_q       <= '0;
      ins_q       <= NOP_INS;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      pc4_q       <= pc4_d;
      ins_q       <= ins_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.q_valid   = valid_q;
  assign bus.q_pc4     = pc4_q;
  assign bus.q_ins     = ins_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Two stage registers (16-bit and 2-bit counters, different NOPs) driven in lockstep
// and compared every edge against a slot/event-level reference model.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP_A = 32'h0000_0000;
  localparam logic [31:0] NOP_B = 32'h0000_0013;
  localparam int          MAX_A = 65535;
  localparam int          MAX_B = 3;

  logic        clock;
  logic        reset;
  logic        wen, flush, d_valid, cnt_clr;
  logic [31:0] d_pc4, d_ins;

  int n_tests;
  int n_fail;

  // Reference state: slot contents plus "bubble" meaning the NOP is presented.
  bit          m_valid;
  bit          m_bub;
  logic [31:0] m_pc4, m_ins;
  int          m_stall_a, m_flush_a, m_stall_b, m_flush_b;

  pipe_stage_reg_if #(.PC_W(32), .INS_W(32), .CNT_W(16)) bus_a ();
  pipe_stage_reg_if #(.PC_W(32), .INS_W(32), .CNT_W(2))  bus_b ();

  assign bus_a.wen = wen;  assign bus_a.flush = flush;  assign bus_a.d_valid = d_valid;
  assign bus_a.d_pc4 = d_pc4;  assign bus_a.d_ins = d_ins;  assign bus_a.cnt_clr = cnt_clr;
  assign bus_b.wen = wen;  assign bus_b.flush = flush;  assign bus_b.d_valid = d_valid;
  assign bus_b.d_pc4 = d_pc4;  assign bus_b.d_ins = d_ins;  assign bus_b.cnt_clr = cnt_clr;

  pipe_stage_reg #(.PC_W(32), .INS_W(32), .NOP_INS(NOP_A), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a)
  );
  pipe_stage_reg #(.PC_W(32), .INS_W(32), .NOP_INS(NOP_B), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int max);
    return (v < max) ? v + 1 : v;
  endfunction

  task automatic compare_all();
    check("a_valid", 32'(bus_a.q_valid), 32'(m_valid));
    check("a_pc4",   bus_a.q_pc4, m_pc4);
    check("a_ins",   bus_a.q_ins, m_bub ? NOP_A : m_ins);
    check("a_stall", 32'(bus_a.stall_cnt), 32'(m_stall_a));
    check("a_flush", 32'(bus_a.flush_cnt), 32'(m_flush_a));
    check("b_valid", 32'(bus_b.q_valid), 32'(m_valid));
    check("b_pc4",   bus_b.q_pc4, m_pc4);
    check("b_ins",   bus_b.q_ins, m_bub ? NOP_B : m_ins);
    check("b_stall", 32'(bus_b.stall_cnt), 32'(m_stall_b));
    check("b_flush", 32'(bus_b.flush_cnt), 32'(m_flush_b));
  endtask

  task automatic step(input bit r, input bit we, input bit fl, input bit dv,
                      input logic [31:0] pc, input logic [31:0] ins, input bit clr);
    bit st_ev, fl_ev;
    reset = r; wen = we; flush = fl; d_valid = dv; d_pc4 = pc; d_ins = ins; cnt_clr = clr;
    st_ev = !fl && !we && m_valid;
    fl_ev = fl && m_valid;
    if (r) begin
      m_valid = 0; m_bub = 1; m_pc4 = '0; m_ins = '0;
      m_stall_a = 0; m_flush_a = 0; m_stall_b = 0; m_flush_b = 0;
    end else begin
      if (fl) begin
        m_valid = 0; m_bub = 1;
      end else if (we) begin
        m_valid = dv; m_pc4 = pc; m_ins = ins; m_bub = !dv;
      end
      if (clr) begin
        m_stall_a = 0; m_flush_a = 0; m_stall_b = 0; m_flush_b = 0;
      end else begin
        if (st_ev) begin m_stall_a = sat_inc(m_stall_a, MAX_A); m_stall_b = sat_inc(m_stall_b, MAX_B); end
        if (fl_ev) begin m_flush_a = sat_inc(m_flush_a, MAX_A); m_flush_b = sat_inc(m_flush_b, MAX_B); end
      end
    end
    @(posedge clock);
    #1;
    compare_all();
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    m_valid = 0; m_bub = 1; m_pc4 = '0; m_ins = '0;
    m_stall_a = 0; m_flush_a = 0; m_stall_b = 0; m_flush_b = 0;
    reset = 1; wen = 0; flush = 0; d_valid = 0; d_pc4 = '0; d_ins = '0; cnt_clr = 0;

    // Reset, then first load.
    step(1, 0, 0, 0, 32'h0, 32'h0, 0);
    step(1, 0, 0, 0, 32'h0, 32'h0, 0);
    check("rst_valid", 32'(bus_a.q_valid), 32'h0);
    check("rst_ins",   bus_a.q_ins, 32'h0);
    check("rst_ins_b", bus_b.q_ins, NOP_B);
    step(0, 1, 0, 1, 32'h0000_0004, 32'h2008_0005, 0);
    check("load_pc4", bus_a.q_pc4, 32'h4);
    check("load_ins", bus_a.q_ins, 32'h2008_0005);

    // Stall three edges, then release.
    repeat (3) step(0, 0, 0, 1, 32'h0000_0008, 32'h2109_0001, 0);
    check("stall_hold_pc4", bus_a.q_pc4, 32'h4);
    check("stall_cnt3", 32'(bus_a.stall_cnt), 32'd3);
    step(0, 1, 0, 1, 32'h0000_0008, 32'h2109_0001, 0);
    check("release_ins", bus_a.q_ins, 32'h2109_0001);

    // Flush over stall, then flush of an empty slot.
    step(0, 0, 1, 1, 32'h0000_000C, 32'h1234_5678, 0);
    check("flush_pc4_hold", bus_a.q_pc4, 32'h8);
    check("flush_cnt1", 32'(bus_a.flush_cnt), 32'd1);
    step(0, 0, 1, 1, 32'h0000_000C, 32'h1234_5678, 0);
    check("flush_cnt_still1", 32'(bus_a.flush_cnt), 32'd1);

    // Invalid load presents NOP; stalls on it are not counted.
    step(0, 1, 0, 0, 32'h0000_0100, 32'hFFFF_FFFF, 0);
    check("inv_ins", bus_a.q_ins, NOP_A);
    check("inv_pc4", bus_a.q_pc4, 32'h100);
    repeat (2) step(0, 0, 0, 1, 32'h0000_0200, 32'hAAAA_5555, 0);
    check("inv_stall_cnt", 32'(bus_a.stall_cnt), 32'd3);

    // Saturation of the 2-bit counter, then clear on a stall edge.
    step(0, 1, 0, 1, 32'h0000_0010, 32'h8C41_0000, 0);
    repeat (5) step(0, 0, 0, 1, 32'h0, 32'h0, 0);
    check("sat_b", 32'(bus_b.stall_cnt), 32'd3);
    check("sat_a", 32'(bus_a.stall_cnt), 32'd8);
    step(0, 0, 0, 1, 32'h0, 32'h0, 1);
    check("clr_b", 32'(bus_b.stall_cnt), 32'd0);
    check("clr_hold_valid", 32'(bus_a.q_valid), 32'd1);

    // Reset wins over a simultaneous flush/stall; load right after.
    step(1, 0, 1, 1, 32'h0000_0020, 32'h0, 0);
    check("rst_mid_valid", 32'(bus_a.q_valid), 32'h0);
    step(0, 1, 0, 1, 32'h0000_0040, 32'h0100_0008, 0);
    check("post_rst_load", bus_a.q_ins, 32'h0100_0008);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) != 0),
           $urandom, $urandom,
           ($urandom_range(0, 24) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised IF/ID-style pipeline stage register for the pipelined CPU. It latches a PC-width field and an instruction field, and carries a valid bit. It supports stall (hold), flush (bubble injection with a NOP instruction) and saturating performance counters for stall and flush events. It sits between any two pipeline stages and is driven by the hazard unit (load/stall enable) and branch logic (flush).

Parameters:
PC_W, 32, width of pc4 field
INS_W, 32, width of instruction field
NOP_INS, 32'h0000_0000, instruction pattern injected on flush/reset (MIPS sll $0,$0,0); width INS_W
CNT_W, 16, width of each performance counter

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
wen  input  1  load enable; 1 = capture inputs, 0 = stall (hold contents)
flush  input  1  1 = inject bubble next edge
d_valid  input  1  incoming slot holds a real instruction
d_pc4  input  PC_W  incoming PC+4
d_ins  input  INS_W  incoming instruction
cnt_clr  input  1  synchronous clear of both counters
q_valid  output  1  registered valid
q_pc4  output  PC_W  registered PC+4
q_ins  output  INS_W  registered instruction
stall_cnt  output  CNT_W  cycles stalled while holding a valid slot
flush_cnt  output  CNT_W  number of flushes that killed a valid instruction

Behaviour:
- One clock, one clock domain; reset is synchronous and active-high; all state updates occur on the rising edge of clock.
- All outputs are registered; latency from d_* to q_* is exactly 1 cycle when loading.
- Reset values: q_valid=0, q_pc4=0, q_ins=NOP_INS, stall_cnt=0, flush_cnt=0.
- Per-edge priority for the data path: reset > flush > stall (wen=0) > load (wen=1).
  - reset: apply reset values; the counters clear as well.
  - flush=1 (any wen): q_valid<=0, q_ins<=NOP_INS, q_pc4 holds its previous value. Flush overrides stall.
  - wen=0, flush=0: q_valid, q_pc4 and q_ins all hold.
  - wen=1, flush=0: q_valid<=d_valid, q_pc4<=d_pc4, q_ins<=d_ins. If d_valid=0, q_ins<=NOP_INS instead of d_ins, so an invalid slot never presents a live instruction.
- Counter priority: reset > cnt_clr > increment.
  - stall_cnt increments on an edge where flush=0, wen=0 and q_valid=1 (pre-edge value).
  - flush_cnt increments on an edge where flush=1 and q_valid=1 (pre-edge value).
  - Both counters saturate at 2^CNT_W-1 and never wrap.
  - cnt_clr=1 clears both counters; an increment on the same edge is discarded (counter reads 0).
- Counters are independent of the data path. A cnt_clr during a stall does not release the stall.
- Reset asserted during a stall or flush wins that edge. The first load is accepted on the first edge after reset deasserts.
- There is no combinational path from any input to any output.

Test Plan:
- Reset then load: hold reset for 2 edges -> q_valid=0, q_ins=0, q_pc4=0. Then wen=1, d_valid=1, d_pc4=0x0000_0004, d_ins=0x2008_0005 -> next edge q_valid=1, q_pc4=0x4, q_ins=0x2008_0005.
- Stall: after the load above, wen=0 for 3 edges with new d_* = 0x8 / 0x2109_0001 -> q_* unchanged (0x4 / 0x2008_0005) and stall_cnt=3. Then wen=1 -> q_pc4=0x8, q_ins=0x2109_0001.
- Flush over stall: with a valid slot held, drive wen=0 and flush=1 for one edge -> q_valid=0, q_ins=NOP_INS, q_pc4 unchanged, flush_cnt=1, stall_cnt unchanged. A second flush with q_valid=0 -> flush_cnt stays 1.
- Invalid load: wen=1, d_valid=0, d_ins=0xFFFF_FFFF -> q_valid=0, q_ins=NOP_INS, q_pc4=d_pc4. Following stall edges do not increment stall_cnt.
- Saturation and clear: CNT_W=2, hold a valid slot with wen=0 for 5 edges -> stall_cnt=3 (no wrap). Then cnt_clr=1 with wen=0 on the same edge -> stall_cnt=0.
- Reset mid-stall: drive wen=0, flush=1 and reset=1 together -> all reset values next edge, including counters=0. Deassert reset with wen=1 -> load accepted on that edge.
